pc_sequencer: RTL

- Fetch/branch control FSM that drives the program counter's Load_PC/Inc_PC strobes.
- Consumes the fetched instruction word and the ALU zero flag.
- Sequences fetch, decode, branch and execute-handoff for the RISC-SPM datapath.
- Non-branch instructions are handed to the datapath controller via an exec_req/exec_done handshake.

---
 rtl/pc_seq_pkg.sv | 68 ++++++
 rtl/pc_seq_decode.sv | 21 ++
 rtl/pc_sequencer.sv | 112 +++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types for the RISC-SPM fetch/branch sequencer: states, opcodes, decode classes, strobes.
package pc_seq_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_NOP  = 4'b0000;
    localparam logic [OP_W-1:0] OP_BR   = 4'b0111;
    localparam logic [OP_W-1:0] OP_BRZ  = 4'b1000;
    localparam logic [OP_W-1:0] OP_HALT = 4'b1111;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_FET1 = 4'd1,
        S_FET2 = 4'd2,
        S_DEC  = 4'd3,
        S_BR1  = 4'd4,
        S_BR2  = 4'd5,
        S_SKIP = 4'd6,
        S_EXEC = 4'd7,
        S_HALT = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        CL_RETIRE = 3'd0,
        CL_HALT   = 3'd1,
        CL_BRANCH = 3'd2,
        CL_SKIP   = 3'd3,
        CL_EXEC   = 3'd4
    } dec_class_t;

    typedef struct packed {
        logic load_pc;
        logic inc_pc;
        logic load_ir;
        logic load_add_r;
        logic sel_pc;
        logic sel_mem;
        logic exec_req;
        logic halted;
    } strobes_t;

    // Moore strobe decode; evaluated on the next state so the output flops track state_q.
    function automatic strobes_t state_strobes(state_t s);
        strobes_t st;
        st = '0;
        case (s)
            S_FET1, S_BR1: begin
                st.sel_pc     = 1'b1;
                st.load_add_r = 1'b1;
            end
            S_FET2: begin
                st.sel_mem = 1'b1;
                st.load_ir = 1'b1;
                st.inc_pc  = 1'b1;
            end
            S_BR2: begin
                st.sel_mem = 1'b1;
                st.load_pc = 1'b1;
            end
            S_SKIP:  st.inc_pc   = 1'b1;
            S_EXEC:  st.exec_req = 1'b1;
            S_HALT:  st.halted   = 1'b1;
            default: st = '0;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/pc_seq_decode.sv
// Combinational opcode + zero flag classifier; shared with the datapath controller.
module pc_seq_decode
    import pc_seq_pkg::*;
(
    input  logic [OP_W-1:0] opcode_i,
    input  logic            zero_flag_i,
    output dec_class_t      class_o
);

    always_comb begin
        class_o = CL_EXEC;
        case (opcode_i)
            OP_NOP:  class_o = CL_RETIRE;
            OP_HALT: class_o = CL_HALT;
            OP_BR:   class_o = CL_BRANCH;
            OP_BRZ:  class_o = zero_flag_i ? CL_BRANCH : CL_SKIP;
            default: class_o = CL_EXEC;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/branch control FSM for RISC-SPM with retired-instruction counter.
// Optional single-step halt after each retirement: define PC_SEQ_SINGLE_STEP_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned ws    = 8,
    parameter int unsigned RET_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [ws-1:0]    instr,
    input  logic             zero_flag,
    input  logic             exec_done,
`ifdef PC_SEQ_SINGLE_STEP_EN
    input  logic             step,
`endif
    output logic             Load_PC,
    output logic             Inc_PC,
    output logic             Load_IR,
    output logic             Load_Add_R,
    output logic             Sel_PC,
    output logic             Sel_Mem,
    output logic             exec_req,
    output logic             halted,
    output logic [RET_W-1:0] retired
);

    state_t           state_q, state_d;
    logic [RET_W-1:0] retired_q, retired_d;
    strobes_t         strb_q;
    dec_class_t       dec_class;
    state_t           retire_next;
    logic             retire;
    logic             unused_operand;

    assign unused_operand = ^instr[ws-OP_W-1:0];

    pc_seq_decode u_decode (
        .opcode_i    (instr[ws-1 -: OP_W]),
        .zero_flag_i (zero_flag),
        .class_o     (dec_class)
    );

`ifdef PC_SEQ_SINGLE_STEP_EN
    assign retire_next = step ? S_IDLE : S_FET1;
`else
    assign retire_next = S_FET1;
`endif

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_IDLE: if (run) state_d = S_FET1;
            S_FET1: state_d = S_FET2;
            S_FET2: state_d = S_DEC;
            S_DEC: begin
                case (dec_class)
                    CL_RETIRE: begin
                        retire  = 1'b1;
                        state_d = retire_next;
                    end
                    CL_HALT: begin
                        retire  = 1'b1;
                        state_d = S_HALT;
                    end
                    CL_BRANCH: state_d = S_BR1;
                    CL_SKIP:   state_d = S_SKIP;
                    default:   state_d = S_EXEC;
                endcase
            end
            S_BR1: state_d = S_BR2;
            S_BR2, S_SKIP: begin
                retire  = 1'b1;
                state_d = retire_next;
            end
            S_EXEC: begin
                if (exec_done) begin
                    retire  = 1'b1;
                    state_d = retire_next;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        retired_d = retired_q + RET_W'(retire);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            retired_q <= '0;
            strb_q    <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            strb_q    <= state_strobes(state_d);
        end
    end

    assign Load_PC    = strb_q.load_pc;
    assign Inc_PC     = strb_q.inc_pc;
    assign Load_IR    = strb_q.load_ir;
    assign Load_Add_R = strb_q.load_add_r;
    assign Sel_PC     = strb_q.sel_pc;
    assign Sel_Mem    = strb_q.sel_mem;
    assign exec_req   = strb_q.exec_req;
    assign halted     = strb_q.halted;
    assign retired    = retired_q;

endmodule
